// File: rtl/fb_writer.sv
// fb_writer: packs 24-bit pixels two per 64-bit beat and writes them to DDR as 16-beat AXI4 INCR bursts.
// Latency: 32 fill + 1 addr + 16 data + 1 resp cycles minimum per burst; one burst outstanding at a time.
// Backpressure: PIX_READY only in FILL; AW/W/B hold until their handshakes. Optional FB_WRITER_BRESP_CHECK_EN enables sticky BRESP_ERR.
module fb_writer #(
  parameter int C_M_AXI_THREAD_ID_WIDTH = 1,
  parameter int C_M_AXI_ADDR_WIDTH      = 32,
  parameter int C_M_AXI_DATA_WIDTH      = 64
) (
  input  logic                                 ACLK,
  input  logic                                 ARESETN,
  input  logic                                 START,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]        BASE_ADDR,
  input  logic [15:0]                          FRAME_BURSTS,
  input  logic [23:0]                          PIX_DATA,
  input  logic                                 PIX_VALID,
  output logic                                 PIX_READY,
  output logic                                 BUSY,
  output logic                                 DONE,
  output logic                                 BRESP_ERR,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]        M_AXI_AWADDR,
  output logic [7:0]                           M_AXI_AWLEN,
  output logic [2:0]                           M_AXI_AWSIZE,
  output logic [1:0]                           M_AXI_AWBURST,
  output logic                                 M_AXI_AWLOCK,
  output logic [3:0]                           M_AXI_AWCACHE,
  output logic [2:0]                           M_AXI_AWPROT,
  output logic [3:0]                           M_AXI_AWQOS,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_AWUSER,
  output logic                                 M_AXI_AWVALID,
  input  logic                                 M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]        M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]      M_AXI_WSTRB,
  output logic                                 M_AXI_WLAST,
  output logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_WUSER,
  output logic                                 M_AXI_WVALID,
  input  logic                                 M_AXI_WREADY,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_BID,
  input  logic [1:0]                           M_AXI_BRESP,
  input  logic [C_M_AXI_THREAD_ID_WIDTH-1:0]   M_AXI_BUSER,
  input  logic                                 M_AXI_BVALID,
  output logic                                 M_AXI_BREADY
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t                          r_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_base;
  logic [15:0]                     r_frame_bursts;
  logic [15:0]                     r_burst_cnt;
  logic [4:0]                      r_pix_idx;
  logic [23:0]                     r_pix_lo;
  logic [3:0]                      r_beat_idx;
  logic                            r_pix_ready;
  logic                            r_busy;
  logic                            r_done;
  logic                            r_awvalid;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   r_awaddr;
  logic                            r_wvalid;
  logic                            r_wlast;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_wdata;
  logic                            r_bready;
  logic [C_M_AXI_DATA_WIDTH-1:0]   r_buf [16];

  logic                            w_pix_fire;
  logic [15:0]                     w_next_cnt;
  logic [C_M_AXI_ADDR_WIDTH-1:0]   w_off;

  assign w_pix_fire = PIX_VALID && r_pix_ready;
  assign w_next_cnt = r_burst_cnt + 16'd1;
  // Each burst covers 128 bytes; the sum wraps modulo the address width.
  assign w_off      = C_M_AXI_ADDR_WIDTH'({r_burst_cnt, 7'b0});

  // Burst buffer: an odd pixel completes a beat together with the held even pixel.
  always_ff @(posedge ACLK) begin
    if (w_pix_fire && r_pix_idx[0]) begin
      r_buf[r_pix_idx[4:1]] <= C_M_AXI_DATA_WIDTH'({8'h00, PIX_DATA, 8'h00, r_pix_lo});
    end
  end

  // Frame control FSM with all handshake outputs registered.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state        <= S_IDLE;
      r_base         <= '0;
      r_frame_bursts <= '0;
      r_burst_cnt    <= '0;
      r_pix_idx      <= '0;
      r_pix_lo       <= '0;
      r_beat_idx     <= '0;
      r_pix_ready    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_awvalid      <= 1'b0;
      r_awaddr       <= '0;
      r_wvalid       <= 1'b0;
      r_wlast        <= 1'b0;
      r_wdata        <= '0;
      r_bready       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (START) begin
            if (FRAME_BURSTS != 16'd0) begin
              r_base         <= {BASE_ADDR[C_M_AXI_ADDR_WIDTH-1:7], 7'b0};
              r_frame_bursts <= FRAME_BURSTS;
              r_burst_cnt    <= '0;
              r_pix_idx      <= '0;
              r_pix_ready    <= 1'b1;
              r_busy         <= 1'b1;
              r_state        <= S_FILL;
            end else begin
              // Empty frame: report completion without ever going busy.
              r_done <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (w_pix_fire) begin
            if (!r_pix_idx[0]) begin
              r_pix_lo <= PIX_DATA;
            end
            r_pix_idx <= r_pix_idx + 5'd1;
            if (r_pix_idx == 5'd31) begin
              r_pix_ready <= 1'b0;
              r_awvalid   <= 1'b1;
              r_awaddr    <= r_base + w_off;
              r_state     <= S_ADDR;
            end
          end
        end
        S_ADDR: begin
          if (M_AXI_AWREADY) begin
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b1;
            r_wdata    <= r_buf[4'd0];
            r_wlast    <= 1'b0;
            r_beat_idx <= 4'd0;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (M_AXI_WREADY) begin
            if (r_beat_idx == 4'd15) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= S_RESP;
            end else begin
              r_beat_idx <= r_beat_idx + 4'd1;
              r_wdata    <= r_buf[r_beat_idx + 4'd1];
              r_wlast    <= (r_beat_idx == 4'd14);
            end
          end
        end
        S_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_burst_cnt <= w_next_cnt;
            if (w_next_cnt == r_frame_bursts) begin
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_pix_idx   <= '0;
              r_pix_ready <= 1'b1;
              r_state     <= S_FILL;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef FB_WRITER_BRESP_CHECK_EN
  logic r_bresp_err;

  // Sticky error: set by any non-OKAY response, cleared by the next accepted START.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_bresp_err <= 1'b0;
    end else if (r_state == S_IDLE && START) begin
      r_bresp_err <= 1'b0;
    end else if (r_state == S_RESP && M_AXI_BVALID && M_AXI_BRESP != 2'b00) begin
      r_bresp_err <= 1'b1;
    end
  end

  assign BRESP_ERR = r_bresp_err;
`else
  logic w_unused_bresp;
  assign w_unused_bresp = ^M_AXI_BRESP;
  assign BRESP_ERR      = 1'b0;
`endif

  logic w_unused_b;
  assign w_unused_b = ^{M_AXI_BID, M_AXI_BUSER};

  assign PIX_READY     = r_pix_ready;
  assign BUSY          = r_busy;
  assign DONE          = r_done;
  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = r_awaddr;
  assign M_AXI_AWLEN   = 8'd15;
  assign M_AXI_AWSIZE  = 3'd3;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WLAST   = r_wlast;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = r_bready;

endmodule

// File: tb/tb_fb_writer.sv
// tb_fb_writer: randomized scoreboard bench for fb_writer with an AXI write-slave model and pixel producer.
// Expected AW addresses and W beats are derived from the pixel list and frame parameters.
// Define FB_WRITER_BRESP_CHECK_EN for both bench and RTL to exercise the sticky error flag.
module tb_fb_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        START;
  logic [31:0] BASE_ADDR;
  logic [15:0] FRAME_BURSTS;
  logic [23:0] PIX_DATA;
  logic        PIX_VALID;
  logic        PIX_READY, BUSY, DONE, BRESP_ERR;
  logic [0:0]  AWID, AWUSER, WUSER, BID, BUSER;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE, AWPROT;
  logic [1:0]  AWBURST, BRESP;
  logic        AWLOCK;
  logic [3:0]  AWCACHE, AWQOS;
  logic        AWVALID, AWREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST, WVALID, WREADY;
  logic        BVALID, BREADY;

  always #5 clk = ~clk;

  fb_writer dut (
    .ACLK(clk), .ARESETN(rst_n), .START(START), .BASE_ADDR(BASE_ADDR),
    .FRAME_BURSTS(FRAME_BURSTS), .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY), .BUSY(BUSY), .DONE(DONE), .BRESP_ERR(BRESP_ERR),
    .M_AXI_AWID(AWID), .M_AXI_AWADDR(AWADDR), .M_AXI_AWLEN(AWLEN),
    .M_AXI_AWSIZE(AWSIZE), .M_AXI_AWBURST(AWBURST), .M_AXI_AWLOCK(AWLOCK),
    .M_AXI_AWCACHE(AWCACHE), .M_AXI_AWPROT(AWPROT), .M_AXI_AWQOS(AWQOS),
    .M_AXI_AWUSER(AWUSER), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WLAST(WLAST),
    .M_AXI_WUSER(WUSER), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BID(BID), .M_AXI_BRESP(BRESP), .M_AXI_BUSER(BUSER),
    .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] aw_q[$];
  logic [64:0] w_q[$];     // {wlast, wdata}
  logic [23:0] pix_q[$];

  bit stall_en = 0;
  int bad_burst = -1;
  int b_idx = 0;
  int pending_b = 0;
  bit pix_fire_seen = 0, wlast_seen = 0, b_seen = 0;
  int pix_cnt = 0, done_cnt = 0, aw_cnt = 0, beats_seen = 0;
  bit aw_hold = 0, w_hold = 0;
  logic [31:0] aw_hold_addr;
  logic [64:0] w_hold_dat;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: addresses and beats straight from the frame description.
  task automatic build_frame(input logic [31:0] base, input int n, input bit seq);
    logic [23:0] p[32];
    for (int b = 0; b < n; b++) begin
      aw_q.push_back((base & 32'hFFFF_FF80) + 32'(b) * 32'd128);
      for (int i = 0; i < 32; i++) begin
        p[i] = seq ? 24'(b * 32 + i + 1) : 24'($urandom);
        pix_q.push_back(p[i]);
      end
      for (int k = 0; k < 16; k++)
        w_q.push_back({k == 15, 8'h00, p[2*k+1], 8'h00, p[2*k]});
    end
  endtask

  // Pixel producer: presents queued pixels, with random gaps when stalling.
  always @(posedge clk) begin
    #1;
    if (pix_fire_seen) begin
      pix_fire_seen = 0;
      if (pix_q.size() > 0) void'(pix_q.pop_front());
    end
    if (pix_q.size() > 0 && (!stall_en || $urandom_range(0, 3) != 0)) begin
      PIX_VALID = 1;
      PIX_DATA  = pix_q[0];
    end else begin
      PIX_VALID = 0;
    end
  end

  // Write slave: random ready, one B per completed burst, BVALID held until taken.
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; pending_b = 0;
      b_seen = 0; wlast_seen = 0;
    end else begin
      if (b_seen) begin b_seen = 0; pending_b--; BVALID = 0; end
      if (wlast_seen) begin wlast_seen = 0; pending_b++; end
      AWREADY = !stall_en || ($urandom_range(0, 1) == 1);
      WREADY  = !stall_en || ($urandom_range(0, 1) == 1);
      if (!BVALID && pending_b > 0 && (!stall_en || $urandom_range(0, 1) == 1)) begin
        BVALID = 1;
        BRESP  = (b_idx == bad_burst) ? 2'b10 : 2'b00;
      end
    end
  end

  // Monitor: pops the scoreboard on every handshake and checks hold stability.
  always @(negedge clk) begin
    if (!rst_n) begin
      aw_hold = 0; w_hold = 0;
    end else begin
      if (aw_hold) begin
        check("aw_stall_valid", AWVALID, 1);
        check("aw_stall_addr", AWADDR, aw_hold_addr);
      end
      if (w_hold) begin
        check("w_stall_valid", WVALID, 1);
        check("w_stall_data", {WLAST, WDATA}, w_hold_dat);
      end
      aw_hold = AWVALID && !AWREADY; aw_hold_addr = AWADDR;
      w_hold  = WVALID && !WREADY;   w_hold_dat = {WLAST, WDATA};
      if (AWVALID && AWREADY) begin
        aw_cnt++;
        check("aw_expected", aw_q.size() != 0, 1);
        if (aw_q.size() != 0) check("awaddr", AWADDR, aw_q.pop_front());
        check("aw_len_size_burst_cache", {AWLEN, AWSIZE, AWBURST, AWCACHE}, {8'd15, 3'd3, 2'b01, 4'b0011});
      end
      if (WVALID && WREADY) begin
        beats_seen++;
        check("w_expected", w_q.size() != 0, 1);
        if (w_q.size() != 0) check("wlast_wdata", {WLAST, WDATA}, w_q.pop_front());
        check("wstrb", WSTRB, 8'hFF);
        if (WLAST) wlast_seen = 1;
      end
      if (BVALID && BREADY) begin b_seen = 1; b_idx++; end
      if (PIX_VALID && PIX_READY) begin pix_fire_seen = 1; pix_cnt++; end
      check("pix_ready_only_in_fill", PIX_READY && (AWVALID || WVALID || BREADY), 0);
      if (DONE) done_cnt++;
    end
  end

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] n);
    @(posedge clk); #1;
    START = 1; BASE_ADDR = base; FRAME_BURSTS = n;
    @(posedge clk); #1;
    START = 0;
    check("start_busy", BUSY, 1);
    check("start_pix_ready", PIX_READY, 1);
    check("start_bresp_err_clear", BRESP_ERR, 0);
  endtask

  task automatic run_frame(input logic [31:0] base, input int n, input bit seq,
                           input bit stall, input int bad, input bit glitch);
    int d0, p0, cyc;
    logic exp_err;
    stall_en = stall; bad_burst = bad; b_idx = 0;
    d0 = done_cnt; p0 = pix_cnt;
    build_frame(base, n, seq);
    pulse_start(base, 16'(n));
    cyc = 0;
    while (done_cnt == d0 && cyc < 20000) begin
      @(negedge clk); #2;
      cyc++;
      if (glitch && cyc == 40) begin START = 1; FRAME_BURSTS = 16'd7; end
      if (glitch && cyc == 41) START = 0;
    end
    check("frame_done_count", 64'(done_cnt - d0), 1);
    check("done_pulse_high", DONE, 1);
    check("busy_low_at_done", BUSY, 0);
    check("pixels_accepted", 64'(pix_cnt - p0), 64'(n * 32));
    check("aw_queue_drained", aw_q.size(), 0);
    check("w_queue_drained", w_q.size(), 0);
`ifdef FB_WRITER_BRESP_CHECK_EN
    exp_err = (bad >= 0 && bad < n);
`else
    exp_err = 1'b0;
`endif
    check("bresp_err", BRESP_ERR, exp_err);
    @(negedge clk); #2;
    check("done_single_cycle", DONE, 0);
    stall_en = 0;
  endtask

  initial begin
    int a0, bs0, cyc;
    rst_n = 0; START = 0; BASE_ADDR = 0; FRAME_BURSTS = 0;
    PIX_DATA = 0; PIX_VALID = 0; BRESP = 0; BID = 0; BUSER = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {PIX_READY, BUSY, DONE, AWVALID, WVALID, WLAST, BREADY, BRESP_ERR}, 8'h00);
    check("reset_awaddr", AWADDR, 0);
    @(negedge clk); rst_n = 1;

    run_frame(32'h1000_0000, 1, 1, 0, -1, 0);
    run_frame(32'h2000_0045, 3, 0, 0, -1, 0);
    run_frame(32'h2000_0045, 3, 0, 1, -1, 0);

    // Empty frame: DONE one cycle after START, BUSY never rises, no address issued.
    a0 = aw_cnt;
    @(posedge clk); #1; START = 1; FRAME_BURSTS = 0;
    @(posedge clk); #1; START = 0;
    check("zero_done", DONE, 1);
    check("zero_busy", BUSY, 0);
    check("zero_pix_ready", PIX_READY, 0);
    @(posedge clk); #1;
    check("zero_done_drop", DONE, 0);
    repeat (4) @(posedge clk);
    check("zero_no_aw", 64'(aw_cnt - a0), 0);

    run_frame(32'h4000_0000, 2, 0, 1, 1, 0);
    run_frame(32'h5000_0000, 2, 0, 0, -1, 1);
    run_frame(32'hFFFF_FF80, 2, 0, 1, -1, 0);

    // Reset while beat 7 is on the bus.
    build_frame(32'h3000_0000, 1, 0);
    pulse_start(32'h3000_0000, 16'd1);
    bs0 = beats_seen; cyc = 0;
    while (beats_seen - bs0 < 8 && cyc < 2000) begin @(negedge clk); #2; cyc++; end
    check("reached_beat7", 64'(beats_seen - bs0), 8);
    rst_n = 0;
    #1;
    check("abort_valids", {AWVALID, WVALID, BREADY, PIX_READY, BUSY}, 5'b0);
    aw_q.delete(); w_q.delete(); pix_q.delete(); pix_fire_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    run_frame(32'h3000_0000, 1, 0, 1, -1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
